// File: rtl/match_referee.sv
// match_referee: round referee for the fighting-game core.
// Tracks both players' health and hit invulnerability, runs the round clock
// from 60 Hz ticks and reports game over plus the winner to the state controller.
// Optional build macro: SUDDEN_DEATH_EN (equal-health time-out enters SUDDEN_DEATH
// instead of ending as a draw).
module match_referee #(
    parameter int unsigned MAX_HEALTH    = 100,
    parameter int unsigned HP_W          = 8,
    parameter int unsigned DMG_W         = 4,
    parameter int unsigned ROUND_SECONDS = 60,
    parameter int unsigned TICKS_PER_SEC = 60,
    parameter int unsigned INVULN_TICKS  = 30
) (
    input  logic             clk_game,
    input  logic             reset,
    input  logic             reset_gameplay,
    input  logic             timer_reset,
    input  logic             timer_enable,
    input  logic             dmg_p1_valid,
    input  logic [DMG_W-1:0] dmg_p1_amt,
    input  logic             dmg_p2_valid,
    input  logic [DMG_W-1:0] dmg_p2_amt,
    output logic [HP_W-1:0]  p1_health,
    output logic [HP_W-1:0]  p2_health,
    output logic [6:0]       time_left_s,
    output logic             p1_invuln,
    output logic             p2_invuln,
    output logic             game_over_condition,
    output logic             winner_p1,
    output logic             winner_p2
);

    localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned INV_W  = $clog2(INVULN_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        FINISHED = 2'd2
`ifdef SUDDEN_DEATH_EN
        ,
        SUDDEN_DEATH = 2'd3
`endif
    } state_t;

    state_t             state, state_nxt;
    logic [TICK_W-1:0]  tick, tick_nxt;
    logic [INV_W-1:0]   inv1, inv1_nxt, inv2, inv2_nxt;
    logic [HP_W-1:0]    hp1_nxt, hp2_nxt;
    logic [6:0]         time_nxt;
    logic               over_nxt, win1_nxt, win2_nxt;
    logic               play, clock_hold;

    // Health minus damage, clamped at zero.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                                input logic [DMG_W-1:0] amt);
        sat_sub = (hp > HP_W'(amt)) ? hp - HP_W'(amt) : '0;
    endfunction

    // Next-state, gameplay update and round-end evaluation.
    always_comb begin
        state_nxt  = state;
        tick_nxt   = tick;
        inv1_nxt   = inv1;
        inv2_nxt   = inv2;
        hp1_nxt    = p1_health;
        hp2_nxt    = p2_health;
        time_nxt   = time_left_s;
        over_nxt   = game_over_condition;
        win1_nxt   = winner_p1;
        win2_nxt   = winner_p2;
        play       = 1'b0;
        clock_hold = 1'b0;

        case (state)
            IDLE: begin
                if (timer_enable) begin
                    state_nxt = ACTIVE;
                    play      = 1'b1;
                end
            end
            ACTIVE: begin
                // Evaluation on registered values; a terminating cycle freezes play.
                if (p1_health == '0 && p2_health == '0) begin
                    state_nxt = FINISHED;
                    over_nxt  = 1'b1;
                end else if (p1_health == '0) begin
                    state_nxt = FINISHED;
                    over_nxt  = 1'b1;
                    win2_nxt  = 1'b1;
                end else if (p2_health == '0) begin
                    state_nxt = FINISHED;
                    over_nxt  = 1'b1;
                    win1_nxt  = 1'b1;
                end else if (time_left_s == '0) begin
                    if (p1_health > p2_health) begin
                        state_nxt = FINISHED;
                        over_nxt  = 1'b1;
                        win1_nxt  = 1'b1;
                    end else if (p2_health > p1_health) begin
                        state_nxt = FINISHED;
                        over_nxt  = 1'b1;
                        win2_nxt  = 1'b1;
                    end else begin
`ifdef SUDDEN_DEATH_EN
                        state_nxt = SUDDEN_DEATH;
`else
                        state_nxt = FINISHED;
                        over_nxt  = 1'b1;
`endif
                    end
                end else if (timer_enable) begin
                    play = 1'b1;
                end
            end
`ifdef SUDDEN_DEATH_EN
            SUDDEN_DEATH: begin
                // Clock pinned at zero; first landed hit decides, invulnerability ignored.
                clock_hold = 1'b1;
                if (timer_enable && (dmg_p1_valid || dmg_p2_valid)) begin
                    state_nxt = FINISHED;
                    over_nxt  = 1'b1;
                    win1_nxt  = dmg_p2_valid && !dmg_p1_valid;
                    win2_nxt  = dmg_p1_valid && !dmg_p2_valid;
                    if (dmg_p1_valid) hp1_nxt = sat_sub(p1_health, dmg_p1_amt);
                    if (dmg_p2_valid) hp2_nxt = sat_sub(p2_health, dmg_p2_amt);
                end
            end
`endif
            FINISHED: begin
                state_nxt = FINISHED;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (play) begin
            if (dmg_p1_valid && inv1 == '0) begin
                hp1_nxt  = sat_sub(p1_health, dmg_p1_amt);
                inv1_nxt = INV_W'(INVULN_TICKS);
            end else if (inv1 != '0) begin
                inv1_nxt = inv1 - INV_W'(1);
            end
            if (dmg_p2_valid && inv2 == '0) begin
                hp2_nxt  = sat_sub(p2_health, dmg_p2_amt);
                inv2_nxt = INV_W'(INVULN_TICKS);
            end else if (inv2 != '0) begin
                inv2_nxt = inv2 - INV_W'(1);
            end
            if (tick == TICK_W'(TICKS_PER_SEC - 1)) begin
                tick_nxt = '0;
                if (time_left_s != '0) time_nxt = time_left_s - 7'd1;
            end else begin
                tick_nxt = tick + TICK_W'(1);
            end
        end

        if (timer_reset && !clock_hold) begin
            time_nxt = 7'(ROUND_SECONDS);
            tick_nxt = '0;
        end

        if (reset_gameplay) begin
            state_nxt = IDLE;
            tick_nxt  = '0;
            inv1_nxt  = '0;
            inv2_nxt  = '0;
            hp1_nxt   = HP_W'(MAX_HEALTH);
            hp2_nxt   = HP_W'(MAX_HEALTH);
            time_nxt  = 7'(ROUND_SECONDS);
            over_nxt  = 1'b0;
            win1_nxt  = 1'b0;
            win2_nxt  = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_game) begin
        if (reset) begin
            state               <= IDLE;
            tick                <= '0;
            inv1                <= '0;
            inv2                <= '0;
            p1_health           <= HP_W'(MAX_HEALTH);
            p2_health           <= HP_W'(MAX_HEALTH);
            time_left_s         <= 7'(ROUND_SECONDS);
            p1_invuln           <= 1'b0;
            p2_invuln           <= 1'b0;
            game_over_condition <= 1'b0;
            winner_p1           <= 1'b0;
            winner_p2           <= 1'b0;
        end else begin
            state               <= state_nxt;
            tick                <= tick_nxt;
            inv1                <= inv1_nxt;
            inv2                <= inv2_nxt;
            p1_health           <= hp1_nxt;
            p2_health           <= hp2_nxt;
            time_left_s         <= time_nxt;
            p1_invuln           <= (inv1_nxt != '0);
            p2_invuln           <= (inv2_nxt != '0);
            game_over_condition <= over_nxt;
            winner_p1           <= win1_nxt;
            winner_p2           <= win2_nxt;
        end
    end

endmodule

// File: tb/tb_match_referee.sv
// Directed bench for match_referee with hand-computed expectations.
module tb_match_referee;

    logic       clk_game = 1'b0;
    logic       reset = 1'b1;
    logic       reset_gameplay = 1'b1;
    logic       timer_reset = 1'b0;
    logic       timer_enable = 1'b0;
    logic       dmg_p1_valid = 1'b0;
    logic [3:0] dmg_p1_amt = 4'd0;
    logic       dmg_p2_valid = 1'b0;
    logic [3:0] dmg_p2_amt = 4'd0;
    logic [7:0] p1_health, p2_health;
    logic [6:0] time_left_s;
    logic       p1_invuln, p2_invuln, game_over_condition, winner_p1, winner_p2;

    int n_vec = 0;
    int n_bad = 0;

    match_referee dut (
        .clk_game            (clk_game),
        .reset               (reset),
        .reset_gameplay      (reset_gameplay),
        .timer_reset         (timer_reset),
        .timer_enable        (timer_enable),
        .dmg_p1_valid        (dmg_p1_valid),
        .dmg_p1_amt          (dmg_p1_amt),
        .dmg_p2_valid        (dmg_p2_valid),
        .dmg_p2_amt          (dmg_p2_amt),
        .p1_health           (p1_health),
        .p2_health           (p2_health),
        .time_left_s         (time_left_s),
        .p1_invuln           (p1_invuln),
        .p2_invuln           (p2_invuln),
        .game_over_condition (game_over_condition),
        .winner_p1           (winner_p1),
        .winner_p2           (winner_p2)
    );

    always #5 clk_game = ~clk_game;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_game);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic hit(input logic v1, input logic [3:0] a1, input logic v2, input logic [3:0] a2);
        dmg_p1_valid = v1;
        dmg_p1_amt   = a1;
        dmg_p2_valid = v2;
        dmg_p2_amt   = a2;
        step(1);
        dmg_p1_valid = 1'b0;
        dmg_p1_amt   = 4'd0;
        dmg_p2_valid = 1'b0;
        dmg_p2_amt   = 4'd0;
    endtask

    // One hit cycle plus the full invulnerability window.
    task automatic hit_wait(input logic v1, input logic [3:0] a1, input logic v2, input logic [3:0] a2);
        hit(v1, a1, v2, a2);
        step(30);
    endtask

    task automatic new_round();
        timer_enable   = 1'b0;
        reset_gameplay = 1'b1;
        step(1);
        reset_gameplay = 1'b0;
        timer_enable   = 1'b1;
    endtask

    initial begin
        // Reset state
        step(2);
        reset = 1'b0;
        step(1);
        check("rst_p1_hp", 32'(p1_health), 32'd100);
        check("rst_p2_hp", 32'(p2_health), 32'd100);
        check("rst_time", 32'(time_left_s), 32'd60);
        check("rst_over", 32'(game_over_condition), 32'd0);
        check("rst_win", 32'({winner_p1, winner_p2, p1_invuln, p2_invuln}), 32'd0);

        // Clock: first second boundary after 60 enabled cycles
        reset_gameplay = 1'b0;
        timer_enable   = 1'b1;
        step(59);
        check("clk_59", 32'(time_left_s), 32'd60);
        step(1);
        check("clk_60", 32'(time_left_s), 32'd59);
        step(1);
        check("clk_61_over", 32'(game_over_condition), 32'd0);
        check("clk_61_hp", 32'({p1_health, p2_health}), 32'({8'd100, 8'd100}));

        // Invulnerability window
        hit(1'b0, 4'd0, 1'b1, 4'd10);
        check("inv_hit1", 32'(p2_health), 32'd90);
        check("inv_flag1", 32'(p2_invuln), 32'd1);
        step(1);
        hit(1'b0, 4'd0, 1'b1, 4'd10);
        check("inv_rehit_ignored", 32'(p2_health), 32'd90);
        step(27);
        check("inv_cycle30", 32'(p2_invuln), 32'd1);
        step(1);
        check("inv_expired", 32'(p2_invuln), 32'd0);
        hit(1'b0, 4'd0, 1'b1, 4'd10);
        check("inv_hit2", 32'(p2_health), 32'd80);
        check("inv_p1_untouched", 32'(p1_health), 32'd100);

        // KO with saturation, winner P1, held until reset_gameplay
        new_round();
        repeat (6) hit_wait(1'b0, 4'd0, 1'b1, 4'd15);
        hit_wait(1'b0, 4'd0, 1'b1, 4'd5);
        check("ko_p2_5", 32'(p2_health), 32'd5);
        hit(1'b0, 4'd0, 1'b1, 4'd15);
        check("ko_sat0", 32'(p2_health), 32'd0);
        check("ko_over_lag", 32'(game_over_condition), 32'd0);
        step(1);
        check("ko_over", 32'(game_over_condition), 32'd1);
        check("ko_win", 32'({winner_p1, winner_p2}), 32'b10);
        timer_enable = 1'b0;
        hit(1'b1, 4'd15, 1'b0, 4'd0);
        timer_enable = 1'b1;
        hit(1'b1, 4'd15, 1'b0, 4'd0);
        step(5);
        check("ko_hold_over", 32'(game_over_condition), 32'd1);
        check("ko_hold_win", 32'({winner_p1, winner_p2}), 32'b10);
        check("ko_hold_hp", 32'({p1_health, p2_health}), 32'({8'd100, 8'd0}));
        reset_gameplay = 1'b1;
        step(1);
        check("rg_over", 32'(game_over_condition), 32'd0);
        check("rg_win", 32'({winner_p1, winner_p2}), 32'd0);
        check("rg_hp", 32'({p1_health, p2_health}), 32'({8'd100, 8'd100}));
        check("rg_time", 32'(time_left_s), 32'd60);
        reset_gameplay = 1'b0;

        // Double KO is a draw
        new_round();
        repeat (6) hit_wait(1'b1, 4'd15, 1'b1, 4'd15);
        hit_wait(1'b1, 4'd6, 1'b1, 4'd6);
        check("dko_hp4", 32'({p1_health, p2_health}), 32'({8'd4, 8'd4}));
        hit(1'b1, 4'd4, 1'b1, 4'd4);
        check("dko_hp0", 32'({p1_health, p2_health}), 32'd0);
        check("dko_over_lag", 32'(game_over_condition), 32'd0);
        step(1);
        check("dko_over", 32'(game_over_condition), 32'd1);
        check("dko_draw", 32'({winner_p1, winner_p2}), 32'd0);

        // Time-out with P1 ahead, pause and timer_reset along the way
        new_round();
        hit_wait(1'b1, 4'd15, 1'b1, 4'd15);
        hit_wait(1'b1, 4'd15, 1'b1, 4'd15);
        hit_wait(1'b0, 4'd0, 1'b1, 4'd15);
        hit_wait(1'b0, 4'd0, 1'b1, 4'd5);
        check("to_hp", 32'({p1_health, p2_health}), 32'({8'd70, 8'd50}));
        check("to_time58", 32'(time_left_s), 32'd58);
        timer_enable = 1'b0;
        hit(1'b1, 4'd15, 1'b0, 4'd0);
        check("pause_hp", 32'(p1_health), 32'd70);
        check("pause_time", 32'(time_left_s), 32'd58);
        timer_enable = 1'b1;
        timer_reset  = 1'b1;
        step(1);
        timer_reset  = 1'b0;
        check("trst_time", 32'(time_left_s), 32'd60);
        check("trst_hp", 32'({p1_health, p2_health}), 32'({8'd70, 8'd50}));
        step(3599);
        check("to_time1", 32'(time_left_s), 32'd1);
        step(1);
        check("to_time0", 32'(time_left_s), 32'd0);
        check("to_over_lag", 32'(game_over_condition), 32'd0);
        step(1);
        check("to_over", 32'(game_over_condition), 32'd1);
        check("to_win", 32'({winner_p1, winner_p2}), 32'b10);
        step(3);
        check("to_frozen", 32'({1'b0, time_left_s, p1_health, p2_health}), 32'({8'd0, 8'd70, 8'd50}));

        // Equal-health time-out
        new_round();
        step(3599);
        check("eq_time1", 32'(time_left_s), 32'd1);
        step(1);
        check("eq_time0", 32'(time_left_s), 32'd0);
        step(1);
`ifdef SUDDEN_DEATH_EN
        check("sd_over0", 32'(game_over_condition), 32'd0);
        step(2);
        check("sd_hold", 32'({game_over_condition, time_left_s}), 32'd0);
        hit(1'b1, 4'd1, 1'b0, 4'd0);
        check("sd_over", 32'(game_over_condition), 32'd1);
        check("sd_win", 32'({winner_p1, winner_p2}), 32'b01);
`else
        check("eq_over", 32'(game_over_condition), 32'd1);
        check("eq_draw", 32'({winner_p1, winner_p2}), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
